painterengine_gpu_dma_reader_arbiter: RTL and testbench

Round-robin scheduler that shares one painterengine GPU DMA reader between four requesters.
- Grants one requester at a time.
- Latches that requester's address and length, and drives the reader's one-hot router.
- Restarts the reader by sequencing its reset, since the reader runs a single job per reset release.
- Reports per-requester completion or error.
- Read data and data_next bypass this block; the reader demuxes them by router.

---
 rtl/painterengine_gpu_dma_reader_arbiter.sv | 162 ++++++++++++++++
 tb/tb_painterengine_gpu_dma_reader_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/painterengine_gpu_dma_reader_arbiter.sv
// Round-robin owner of one painterengine DMA reader shared by four requesters; registered outputs.
// Request to reader release in RESET_CYCLES+1 edges, reader done/error to report pulse in 1 edge.
module painterengine_gpu_dma_reader_arbiter #(
    parameter int RESET_CYCLES  = 2,
    parameter int WATCHDOG_BITS = 24
) (
    input  logic         i_wire_clock,
    input  logic         i_wire_resetn,
    input  logic [3:0]   i_wire_request,
    input  logic [127:0] i_wire_address,
    input  logic [127:0] i_wire_length,
    output logic [3:0]   o_wire_grant,
    output logic [3:0]   o_wire_done,
    output logic [3:0]   o_wire_error,
    output logic [2:0]   o_wire_error_type,
    output logic         o_wire_reader_resetn,
    output logic [3:0]   o_wire_reader_router,
    output logic [127:0] o_wire_reader_address,
    output logic [127:0] o_wire_reader_length,
    input  logic         i_wire_reader_done,
    input  logic         i_wire_reader_error,
    input  logic [2:0]   i_wire_reader_error_type
);

    typedef enum logic [1:0] {IDLE, HOLD, RUN, REPORT} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               rr_q, rr_d;
    logic [1:0]               gidx_q, gidx_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [WATCHDOG_BITS-1:0] wd_q, wd_d;
    logic [WATCHDOG_BITS-1:0] wd_inc;
    logic [3:0]               grant_q, grant_d;
    logic [127:0]             addr_q, addr_d;
    logic [127:0]             len_q, len_d;
    logic                     rstn_q, rstn_d;
    logic [3:0]               done_q, done_d;
    logic [3:0]               err_q, err_d;
    logic [2:0]               etype_q, etype_d;
    logic [1:0]               pick_idx;

    // First set request at or after the pointer, wrapping; lowest offset wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] sel;
        logic [1:0] cand;
        sel = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) sel = cand;
        end
        return sel;
    endfunction

    assign pick_idx = rr_pick(i_wire_request, rr_q);
    assign wd_inc   = wd_q + WATCHDOG_BITS'(1);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gidx_d  = gidx_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        len_d   = len_q;
        rstn_d  = rstn_q;
        done_d  = '0;
        err_d   = '0;
        etype_d = etype_q;
        unique case (state_q)
            IDLE: begin
                rstn_d  = 1'b0;
                grant_d = '0;
                if (|i_wire_request) begin
                    gidx_d  = pick_idx;
                    grant_d = 4'b0001 << pick_idx;
                    addr_d  = '0;
                    len_d   = '0;
                    addr_d[pick_idx*32 +: 32] = i_wire_address[pick_idx*32 +: 32];
                    len_d[pick_idx*32 +: 32]  = i_wire_length[pick_idx*32 +: 32];
                    cnt_d   = 4'(RESET_CYCLES - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    rstn_d  = 1'b1;
                    wd_d    = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RUN: begin
                wd_d = wd_inc;
                // Timeout fires after exactly 2^(WATCHDOG_BITS-1) cycles with the reader released.
                if (i_wire_reader_done) begin
                    done_d[gidx_q] = 1'b1;
                    etype_d        = 3'b000;
                end else if (i_wire_reader_error) begin
                    err_d[gidx_q] = 1'b1;
                    etype_d       = i_wire_reader_error_type;
                end else if (wd_inc[WATCHDOG_BITS-1]) begin
                    err_d[gidx_q] = 1'b1;
                    etype_d       = 3'b110;
                end
                if (i_wire_reader_done || i_wire_reader_error || wd_inc[WATCHDOG_BITS-1]) begin
                    rstn_d  = 1'b0;
                    rr_d    = gidx_q + 2'd1;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                grant_d = '0;
                addr_d  = '0;
                len_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gidx_q  <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            rstn_q  <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            etype_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            rstn_q  <= rstn_d;
            done_q  <= done_d;
            err_q   <= err_d;
            etype_q <= etype_d;
        end
    end

    assign o_wire_grant          = grant_q;
    assign o_wire_reader_router  = grant_q;
    assign o_wire_done           = done_q;
    assign o_wire_error          = err_q;
    assign o_wire_error_type     = etype_q;
    assign o_wire_reader_resetn  = rstn_q;
    assign o_wire_reader_address = addr_q;
    assign o_wire_reader_length  = len_q;

endmodule

// File: tb/tb_painterengine_gpu_dma_reader_arbiter.sv
// Directed bench for the DMA reader arbiter: scripted reader responses, scoreboard of expected reports.
module tb_painterengine_gpu_dma_reader_arbiter;

    localparam int RC = 2;
    localparam int WB = 6;

    typedef struct packed {
        logic [3:0] g;
        logic       err;
        logic [2:0] et;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] addr = '0;
    logic [127:0] len = '0;
    logic [3:0]   grant, done, error, router;
    logic [2:0]   etype;
    logic         rresetn;
    logic [127:0] raddr, rlen;
    logic         rd_done = 1'b0;
    logic         rd_err = 1'b0;
    logic [2:0]   rd_et = '0;

    int   checks = 0;
    int   errors = 0;
    logic [2:0] last_et = '0;
    exp_t sb[$];

    always #5 clk = ~clk;

    painterengine_gpu_dma_reader_arbiter #(.RESET_CYCLES(RC), .WATCHDOG_BITS(WB)) dut (
        .i_wire_clock(clk),
        .i_wire_resetn(rst_n),
        .i_wire_request(req),
        .i_wire_address(addr),
        .i_wire_length(len),
        .o_wire_grant(grant),
        .o_wire_done(done),
        .o_wire_error(error),
        .o_wire_error_type(etype),
        .o_wire_reader_resetn(rresetn),
        .o_wire_reader_router(router),
        .o_wire_reader_address(raddr),
        .o_wire_reader_length(rlen),
        .i_wire_reader_done(rd_done),
        .i_wire_reader_error(rd_err),
        .i_wire_reader_error_type(rd_et)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("inv_grant_onehot", 128'($onehot0(grant)), 128'(1));
            chk("inv_router_eq_grant", router, grant);
            chk("inv_single_pulse", 128'($onehot0({done, error})), 128'(1));
        end
    end

    // mode: 0 reader done, 1 reader error, 2 reader silent (watchdog)
    task automatic do_job(input logic [3:0] rq, input logic [3:0] g, input int mode,
                          input logic [2:0] et, input int delay, input bit keep, input bit poke);
        int n, lowc, runc, li;
        logic [127:0] ea, el;
        bit stable;
        exp_t e, got;
        li = idx_of(g);
        ea = '0;
        el = '0;
        ea[li*32 +: 32] = addr[li*32 +: 32];
        el[li*32 +: 32] = len[li*32 +: 32];
        e = {g, (mode != 0), (mode == 0) ? 3'b000 : (mode == 1) ? et : 3'b110};
        sb.push_back(e);
        req = rq;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == 4'b0 && n < 20);
        chk("grant", grant, g);
        chk("router", router, g);
        chk("reader_address", raddr, ea);
        chk("reader_length", rlen, el);
        chk("error_type_held", etype, last_et);
        if (!keep) req = '0;
        lowc = 0;
        while (rresetn == 1'b0 && lowc < 20) begin
            lowc++;
            @(negedge clk);
        end
        chk("hold_low_cycles", lowc, RC);
        if (poke) addr[127:96] = 32'hDEAD_BEEF;
        runc = 1;
        stable = 1'b1;
        while ((done | error) == 4'b0 && runc < 200) begin
            if (raddr !== ea || rlen !== el || grant !== g || rresetn !== 1'b1) stable = 1'b0;
            if (runc == delay && mode == 0) rd_done = 1'b1;
            if (runc == delay && mode == 1) begin
                rd_err = 1'b1;
                rd_et  = et;
            end
            @(negedge clk);
            if ((done | error) == 4'b0) runc++;
        end
        chk("run_stable", 128'(stable), 128'(1));
        chk("run_cycles", runc, (mode == 2) ? 2 ** (WB - 1) : delay);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 128'(0), 128'(1));
        end else begin
            got = sb.pop_front();
            chk("done_pulse", done, got.err ? 4'b0 : got.g);
            chk("error_pulse", error, got.err ? got.g : 4'b0);
            chk("error_type", etype, got.et);
            last_et = got.et;
        end
        chk("reader_resetn_report", rresetn, 0);
        rd_done = 1'b0;
        rd_err  = 1'b0;
        rd_et   = '0;
        @(negedge clk);
        chk("idle_grant", grant, 0);
        chk("idle_address", raddr, 0);
        chk("idle_length", rlen, 0);
        chk("pulse_cleared", done | error, 0);
        chk("error_type_kept", etype, last_et);
    endtask

    initial begin
        int n;
        addr = {32'h0000_4000, 32'h0000_3000, 32'h0000_1000, 32'h0000_0800};
        len  = {32'd40, 32'd30, 32'd8, 32'd10};
        #12;
        chk("reset_grant", grant, 0);
        chk("reset_pulses", done | error, 0);
        chk("reset_error_type", etype, 0);
        chk("reset_reader_resetn", rresetn, 0);
        chk("reset_lanes", raddr | rlen, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single job on requester 1
        do_job(4'b0010, 4'b0010, 0, 3'b000, 20, 1'b0, 1'b0);

        // fresh reset so round robin starts at requester 0
        rst_n = 1'b0;
        last_et = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_job(4'b1111, 4'b0001, 0, 3'b000, 3, 1'b1, 1'b0);
        do_job(4'b1111, 4'b0010, 0, 3'b000, 4, 1'b1, 1'b0);
        do_job(4'b1111, 4'b0100, 0, 3'b000, 5, 1'b1, 1'b0);
        do_job(4'b1111, 4'b1000, 0, 3'b000, 6, 1'b1, 1'b0);
        do_job(4'b1111, 4'b0001, 0, 3'b000, 2, 1'b0, 1'b0);

        // reader error on requester 2
        do_job(4'b0100, 4'b0100, 1, 3'b010, 4, 1'b0, 1'b0);

        // reset in the middle of a job on requester 1
        req = 4'b0010;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == 4'b0 && n < 20);
        chk("abort_grant", grant, 4'b0010);
        req = '0;
        n = 0;
        while (rresetn == 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_running", rresetn, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_grant_zero", grant, 0);
        chk("abort_router_zero", router, 0);
        chk("abort_reader_resetn", rresetn, 0);
        chk("abort_error_type", etype, 0);
        chk("abort_lanes", raddr | rlen, 0);
        last_et = '0;
        repeat (2) @(negedge clk);
        chk("abort_no_pulse", done | error, 0);
        rst_n = 1'b1;
        // pointer restarts at 0, so requester 0 beats requester 3
        do_job(4'b1001, 4'b0001, 0, 3'b000, 5, 1'b0, 1'b0);

        // watchdog on requester 3
        do_job(4'b1000, 4'b1000, 2, 3'b000, 0, 1'b0, 1'b0);

        // requester 3 drops its request and rewrites its address mid-job
        do_job(4'b1000, 4'b1000, 0, 3'b000, 7, 1'b0, 1'b1);
        @(negedge clk);
        chk("drop_no_regrant", grant, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
